serial_adder_ctrl: RTL
======================

Name: serial_adder_ctrl

Overview:
- Sequences a single 1-bit full-adder slice over W-bit operands, LSB first, one bit per clock, to produce a W-bit add/subtract result.
- Trades area for latency: one adder cell plus shift registers, a bit counter and an FSM, instead of a W-bit ripple chain.
- Sits between an operand producer and a result consumer; both sides use valid/ready handshakes.

Parameters:
- W, 8, operand and result width in bits; must be >= 1.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand request valid.
- in_ready  output  1  controller can accept operands.
- a  input  W  operand A, unsigned or two's complement.
- b  input  W  operand B.
- sub  input  1  0 = A+B, 1 = A-B.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- sum  output  W  result.
- carryout  output  1  final carry; for subtraction, 1 = no borrow.
- overflow  output  1  signed overflow flag.

Behaviour:
- Clock and reset (already decided): one clock, clk. Reset is asynchronous and active-low on rst_n.
- While rst_n=0, regardless of clock:
  - state=IDLE.
  - in_ready=0, out_valid=0.
  - sum=0, carryout=0, overflow=0.
  - Shift registers, carry flop and bit counter cleared.
- in_ready goes to 1 at the first clk edge after rst_n deasserts.

FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - On an edge where in_valid=1 and in_ready=1, capture:
    - a_sh = a
    - b_sh = sub ? ~b : b
    - carry = sub
    - bit counter = 0
    - sum cleared
  - Then move to RUN. Operand ports are not sampled again until the next accept.
- RUN:
  - in_ready=0, out_valid=0.
  - Each edge: the full-adder slice takes a_sh[0], b_sh[0] and carry, combinationally.
  - The slice sum bit shifts into sum[W-1] while sum shifts right; a_sh and b_sh shift right; carry takes the slice carryout.
  - On the edge processing bit W-1 (counter = W-1):
    - Record overflow = carry-in of bit W-1 XOR slice carryout.
    - carryout = slice carryout.
    - Move to DONE.
  - in_valid is ignored in RUN.
- DONE:
  - out_valid=1, in_ready=0.
  - sum, carryout and overflow are held stable until the handshake.
  - On an edge with out_ready=1, move to IDLE. out_valid drops, outputs keep their last values, and in_ready rises on that same edge.
  - There is no same-cycle accept of new operands in DONE.
- Latency: accept edge at cycle k gives out_valid high after edge k+W. Throughput is one operation per W+2 cycles with out_ready held high.
- Arithmetic: sum = (a + (sub ? ~b+1 : b)) mod 2^W, bit-exact to a W-bit ripple adder. W=1 is legal: one RUN cycle, and overflow = carry-in XOR carryout of bit 0.
- Reset mid-operation (RUN or DONE): the operation is abandoned, all outputs clear immediately, and no partial result is ever presented.
- out_ready while not in DONE has no effect.

Test Plan (W=8):
- Reset: assert rst_n=0 mid-clock -> all outputs 0 immediately; release -> in_ready=1 after the first edge, out_valid=0.
- Add: a=8'h3C, b=8'h0F, sub=0 accepted at edge k -> out_valid rises after edge k+8; sum=8'h4B, carryout=0, overflow=0.
- Add boundaries:
  - a=8'hFF, b=8'h01 -> sum=8'h00, carryout=1, overflow=0.
  - a=8'h7F, b=8'h01 -> sum=8'h80, carryout=0, overflow=1.
- Subtract:
  - a=8'h05, b=8'h07, sub=1 -> sum=8'hFE, carryout=0, overflow=0.
  - a=8'h80, b=8'h01, sub=1 -> sum=8'h7F, carryout=1, overflow=1.
  - a=8'h09, b=8'h09, sub=1 -> sum=8'h00, carryout=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while driving in_valid=1 with new operands -> outputs stable, in_ready=0, operands not captured. Raise out_ready -> IDLE next edge, new operands accepted on the following edge, correct result W cycles later.
- Reset in RUN: pulse rst_n low after 3 RUN cycles of 8'hAA+8'h55 -> outputs 0 at once. Then 8'h12+8'h34 -> sum=8'h46 with no corruption.

Source files
------------

// File: rtl/serial_adder_ctrl_if.sv
// Operand/result handshake bundle for the bit-serial adder controller.
// The producer/consumer side uses the master modport, the controller the slave.
interface serial_adder_ctrl_if #(
  parameter int W = 8
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         carryout;
  logic         overflow;

  modport master (
    output in_valid, a, b, sub, out_ready,
    input  in_ready, out_valid, sum, carryout, overflow
  );

  modport slave (
    input  in_valid, a, b, sub, out_ready,
    output in_ready, out_valid, sum, carryout, overflow
  );
endinterface

// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract controller: one full-adder slice is walked over the
// W-bit operands LSB first, one bit per clock, with valid/ready on both sides.
// Subtraction is A + ~B + 1, so the carry flop is preloaded with 'sub'.
module serial_adder_ctrl #(
  parameter int W = 8
) (
  input logic              clk,
  input logic              rst_n,
  serial_adder_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  state_t         state;
  state_t         state_nxt;
  logic [W-1:0]   a_sh;
  logic [W-1:0]   b_sh;
  logic [W-1:0]   sum_r;
  logic [W-1:0]   sum_shift;
  logic [CW-1:0]  cnt;
  logic           carry;
  logic           cout_r;
  logic           ovf_r;
  logic           rdy_r;
  logic           fa_s;
  logic           fa_c;
  logic           accept;
  logic           last_bit;

  assign accept   = (state == IDLE) && rdy_r && bus.in_valid;
  assign last_bit = (cnt == LAST);

  // Single full-adder slice on the low bits plus the shifted-in result word
  always_comb begin
    fa_s      = a_sh[0] ^ b_sh[0] ^ carry;
    fa_c      = (a_sh[0] & b_sh[0]) | (carry & (a_sh[0] ^ b_sh[0]));
    sum_shift = sum_r >> 1;
    sum_shift[W-1] = fa_s;
  end

  // Next-state logic: accept in IDLE, W bit steps in RUN, hold in DONE until taken
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)        state_nxt = RUN;
      RUN:     if (last_bit)      state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default:                    state_nxt = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // in_ready is registered so it stays low during reset and rises one edge later
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdy_r <= 1'b0;
    else        rdy_r <= (state_nxt == IDLE);
  end

  // Operand capture, per-bit shifting and final carry/overflow recording
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      sum_r  <= '0;
      cnt    <= '0;
      carry  <= 1'b0;
      cout_r <= 1'b0;
      ovf_r  <= 1'b0;
    end else if (accept) begin
      a_sh  <= bus.a;
      b_sh  <= bus.sub ? ~bus.b : bus.b;
      carry <= bus.sub;
      cnt   <= '0;
      sum_r <= '0;
    end else if (state == RUN) begin
      a_sh  <= a_sh >> 1;
      b_sh  <= b_sh >> 1;
      carry <= fa_c;
      sum_r <= sum_shift;
      cnt   <= cnt + CW'(1);
      if (last_bit) begin
        cout_r <= fa_c;
        ovf_r  <= carry ^ fa_c;
      end
    end
  end

  assign bus.in_ready  = rdy_r;
  assign bus.out_valid = (state == DONE);
  assign bus.sum       = sum_r;
  assign bus.carryout  = cout_r;
  assign bus.overflow  = ovf_r;

endmodule
